// File: rtl/stash_sequencer.sv
// Button front-end for the sample stash: synchronizes and debounces the capture/step buttons,
// arbitrates capture, manual-step and auto-step requests, and mirrors the stash pointers.
module stash_sequencer #(
    parameter int DEPTH       = 5,
    parameter int DEB_CYCLES  = 4,
    parameter int STEP_PERIOD = 8,
    parameter int HOLDOFF     = 2,
    localparam int PTR_W      = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_sample,
    input  logic             btn_next,
    input  logic             auto_en,
    output logic             sample_in_valid,
    output logic             next_sample,
    output logic [PTR_W-1:0] wr_idx,
    output logic [PTR_W-1:0] rd_idx,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state
);

    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam int TMR_W = $clog2(STEP_PERIOD + 1);
    localparam int HLD_W = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_STEP    = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t             state_r;
    logic [1:0]         sync1_r;
    logic [1:0]         sync2_r;
    logic [1:0]         level_r;
    logic [1:0]         level_prev_r;
    logic [DEB_W-1:0]   deb_cnt_r [2];
    logic               pending_r;
    logic [TMR_W-1:0]   auto_timer_r;
    logic [HLD_W-1:0]   hold_cnt_r;

    logic               sample_req_s;
    logic               next_req_s;
    logic               tick_s;
    logic               have_data_s;
    logic [PTR_W-1:0]   wr_next_s;
    logic [PTR_W-1:0]   rd_next_s;
    logic [CNT_W-1:0]   count_next_s;

    assign state = state_r;

    // Two-flop synchronizers and per-button debounce (bit 0 = sample, bit 1 = next)
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r      <= 2'b00;
            sync2_r      <= 2'b00;
            level_r      <= 2'b00;
            level_prev_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_r[i] <= '0;
            end
        end else begin
            sync1_r      <= {btn_next, btn_sample};
            sync2_r      <= sync1_r;
            level_prev_r <= level_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == level_r[i]) begin
                    deb_cnt_r[i] <= '0;
                end else if (deb_cnt_r[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    level_r[i]   <= sync2_r[i];
                    deb_cnt_r[i] <= '0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + 1'b1;
                end
            end
        end
    end

    // Press requests, auto tick and the wrapped/saturated pointer successors
    always_comb begin
        sample_req_s = level_r[0] & ~level_prev_r[0];
        next_req_s   = level_r[1] & ~level_prev_r[1];
        have_data_s  = (count != '0);
        tick_s       = auto_en && have_data_s && (auto_timer_r == TMR_W'(STEP_PERIOD - 1));
        if (wr_idx == PTR_W'(DEPTH - 1)) begin
            wr_next_s = '0;
        end else begin
            wr_next_s = wr_idx + 1'b1;
        end
        if (rd_idx == PTR_W'(DEPTH - 1)) begin
            rd_next_s = '0;
        end else begin
            rd_next_s = rd_idx + 1'b1;
        end
        if (count == CNT_W'(DEPTH)) begin
            count_next_s = count;
        end else begin
            count_next_s = count + 1'b1;
        end
    end

    // Sequencer FSM with registered strobes, shadow pointers, pending flag and timers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            sample_in_valid <= 1'b0;
            next_sample     <= 1'b0;
            wr_idx          <= '0;
            rd_idx          <= '0;
            count           <= '0;
            pending_r       <= 1'b0;
            auto_timer_r    <= '0;
            hold_cnt_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    hold_cnt_r <= '0;
                    if (sample_req_s || pending_r) begin
                        state_r         <= ST_CAPTURE;
                        sample_in_valid <= 1'b1;
                        next_sample     <= 1'b0;
                        pending_r       <= 1'b0;
                        auto_timer_r    <= '0;
                    end else if ((next_req_s || tick_s) && have_data_s) begin
                        state_r         <= ST_STEP;
                        sample_in_valid <= 1'b0;
                        next_sample     <= 1'b1;
                        auto_timer_r    <= '0;
                    end else begin
                        sample_in_valid <= 1'b0;
                        next_sample     <= 1'b0;
                        if (auto_en && have_data_s) begin
                            auto_timer_r <= auto_timer_r + 1'b1;
                        end else begin
                            auto_timer_r <= '0;
                        end
                    end
                end
                ST_CAPTURE: begin
                    state_r         <= ST_HOLD;
                    sample_in_valid <= 1'b0;
                    next_sample     <= 1'b0;
                    rd_idx          <= wr_idx;
                    wr_idx          <= wr_next_s;
                    count           <= count_next_s;
                    auto_timer_r    <= '0;
                    hold_cnt_r      <= '0;
                    if (sample_req_s) begin
                        pending_r <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_r         <= ST_HOLD;
                    sample_in_valid <= 1'b0;
                    next_sample     <= 1'b0;
                    rd_idx          <= rd_next_s;
                    auto_timer_r    <= '0;
                    hold_cnt_r      <= '0;
                    if (sample_req_s) begin
                        pending_r <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    sample_in_valid <= 1'b0;
                    next_sample     <= 1'b0;
                    auto_timer_r    <= '0;
                    if (sample_req_s) begin
                        pending_r <= 1'b1;
                    end
                    if (hold_cnt_r == HLD_W'(HOLDOFF - 1)) begin
                        state_r    <= ST_IDLE;
                        hold_cnt_r <= '0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    sample_in_valid <= 1'b0;
                    next_sample     <= 1'b0;
                    auto_timer_r    <= '0;
                    hold_cnt_r      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stash_sequencer.sv
// Directed bench for stash_sequencer with default parameters (DEPTH=5, DEB_CYCLES=4,
// STEP_PERIOD=8, HOLDOFF=2); expected values are hand-derived edge by edge.
module tb_stash_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_sample;
    logic       btn_next;
    logic       auto_en;
    logic       sample_in_valid;
    logic       next_sample;
    logic [2:0] wr_idx;
    logic [2:0] rd_idx;
    logic [3:0] count;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    stash_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .btn_sample      (btn_sample),
        .btn_next        (btn_next),
        .auto_en         (auto_en),
        .sample_in_valid (sample_in_valid),
        .next_sample     (next_sample),
        .wr_idx          (wr_idx),
        .rd_idx          (rd_idx),
        .count           (count),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full press/release of one button; returns how many strobes were seen meanwhile
    task automatic press(input bit which, output int strobes);
        strobes = 0;
        if (which) btn_next = 1'b1; else btn_sample = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            strobes += int'(sample_in_valid) + int'(next_sample);
        end
        if (which) btn_next = 1'b0; else btn_sample = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            strobes += int'(sample_in_valid) + int'(next_sample);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int s;
        int n;
        int exp_wr [6] = '{1, 2, 3, 4, 0, 1};
        int exp_cnt[6] = '{1, 2, 3, 4, 5, 5};
        int exp_rd [6] = '{0, 1, 2, 3, 4, 0};
        int exp_step[5] = '{1, 2, 3, 4, 0};
        int exp_auto[4] = '{2, 3, 4, 0};

        reset = 1'b1; btn_sample = 1'b0; btn_next = 1'b0; auto_en = 1'b0;
        tick(); tick();
        // Test 1: button high before the last reset edge (edge 0)
        btn_sample = 1'b1;
        tick();
        chk("rst_state", state, 0);
        chk("rst_valid", sample_in_valid, 0);
        chk("rst_next", next_sample, 0);
        chk("rst_wr", wr_idx, 0);
        chk("rst_rd", rd_idx, 0);
        chk("rst_count", count, 0);
        reset = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("t1_idle_wait", state, 0);
        end
        tick();
        chk("t1_valid_e7", sample_in_valid, 1);
        chk("t1_state_e7", state, 1);
        tick();
        chk("t1_valid_e8", sample_in_valid, 0);
        chk("t1_state_e8", state, 3);
        chk("t1_wr", wr_idx, 1);
        chk("t1_rd", rd_idx, 0);
        chk("t1_count", count, 1);
        tick();
        chk("t1_state_e9", state, 3);
        tick();
        chk("t1_state_e10", state, 0);
        btn_sample = 1'b0;
        repeat (10) tick();

        // Test 2: three-cycle glitch is rejected; step with empty stash is dropped
        do_reset();
        btn_sample = 1'b1;
        repeat (3) tick();
        btn_sample = 1'b0;
        s = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            s += int'(sample_in_valid);
        end
        chk("t2_glitch_strobes", s, 0);
        chk("t2_glitch_count", count, 0);
        press(1'b1, s);
        chk("t2_empty_next_strobes", s, 0);
        chk("t2_empty_next_rd", rd_idx, 0);

        // Test 3: six captures wrap wr_idx and saturate count, then five steps
        for (int i = 0; i < 6; i++) begin
            press(1'b0, s);
            chk("t3_cap_strobes", s, 1);
            chk("t3_wr", wr_idx, exp_wr[i]);
            chk("t3_count", count, exp_cnt[i]);
            chk("t3_rd", rd_idx, exp_rd[i]);
        end
        for (int i = 0; i < 5; i++) begin
            press(1'b1, s);
            chk("t3_step_strobes", s, 1);
            chk("t3_step_rd", rd_idx, exp_step[i]);
            chk("t3_step_count", count, 5);
        end

        // Test 4: auto-play with two samples steps every 11 cycles
        do_reset();
        press(1'b0, s);
        press(1'b0, s);
        chk("t4_pre_count", count, 2);
        chk("t4_pre_rd", rd_idx, 1);
        auto_en = 1'b1;
        n = 0;
        while (next_sample !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("t4_first_pulse", next_sample, 1);
        for (int p = 0; p < 4; p++) begin
            tick();
            chk("t4_auto_rd", rd_idx, exp_auto[p]);
            if (p < 3) begin
                n = 1;
                while (next_sample !== 1'b1 && n < 30) begin
                    tick();
                    n++;
                end
                chk("t4_period", n, 11);
            end
        end
        auto_en = 1'b0;
        s = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            s += int'(next_sample);
        end
        chk("t4_stopped", s, 0);
        chk("t4_timer_clear", dut.auto_timer_r, 0);
        chk("t4_rd_hold", rd_idx, 0);

        // Test 5a: sample request during HOLD is pended; capture follows first IDLE cycle
        btn_next = 1'b1;
        tick(); tick();
        btn_sample = 1'b1;
        repeat (4) tick();
        tick();
        chk("t5a_next_e6", next_sample, 1);
        tick();
        chk("t5a_rd_e7", rd_idx, 1);
        chk("t5a_state_e7", state, 3);
        tick();
        tick();
        chk("t5a_idle_e9", state, 0);
        chk("t5a_novalid_e9", sample_in_valid, 0);
        tick();
        chk("t5a_valid_e10", sample_in_valid, 1);
        tick();
        chk("t5a_wr", wr_idx, 3);
        chk("t5a_rd", rd_idx, 2);
        chk("t5a_count", count, 3);
        btn_next = 1'b0; btn_sample = 1'b0;
        repeat (12) tick();

        // Test 5b: step request during HOLD is dropped
        btn_sample = 1'b1;
        tick(); tick();
        btn_next = 1'b1;
        repeat (4) tick();
        tick();
        chk("t5b_valid_e6", sample_in_valid, 1);
        s = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            s += int'(next_sample) + int'(sample_in_valid);
        end
        chk("t5b_no_strobe", s, 0);
        chk("t5b_rd", rd_idx, 3);
        chk("t5b_wr", wr_idx, 4);
        chk("t5b_state", state, 0);
        btn_next = 1'b0; btn_sample = 1'b0;
        repeat (12) tick();

        // Test 6: reset during CAPTURE aborts it
        chk("t6_pre_count", count, 4);
        btn_sample = 1'b1;
        repeat (7) tick();
        chk("t6_in_capture", state, 1);
        reset = 1'b1;
        tick();
        chk("t6_state", state, 0);
        chk("t6_valid", sample_in_valid, 0);
        chk("t6_count", count, 0);
        chk("t6_wr", wr_idx, 0);
        chk("t6_rd", rd_idx, 0);
        reset = 1'b0;
        btn_sample = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stash_sequencer.md
Name: stash_sequencer

Overview:
- Control front-end for the 8-bit sample stash. Turns raw, bouncy board buttons and an auto-play switch into clean single-cycle sample_in_valid and next_sample strobes for the stash.
- Arbitrates between capture, manual step and timed auto-step requests, with capture taking priority.
- Keeps shadow write/read indices and a fill count that mirror the stash's internal pointers, for display.
- Sits between the BASYS3 button inputs and the stash instance.

Parameters:
- DEPTH, 5: stash depth. Shadow indices wrap at DEPTH. Must be ≥ 2.
- DEB_CYCLES, 4: number of consecutive stable synchronized cycles needed to accept a button level change. Must be ≥ 2.
- STEP_PERIOD, 8: number of IDLE cycles between auto-steps. Must be ≥ 1.
- HOLDOFF, 2: number of HOLD cycles after any strobe. Must be ≥ 1.
- PTR_W is derived: 1 if DEPTH ≤ 2, else clog2(DEPTH).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_sample  in  1  raw, asynchronous capture button
- btn_next  in  1  raw, asynchronous step button
- auto_en  in  1  auto-play enable; already synchronous, used directly
- sample_in_valid  out  1  capture strobe to stash
- next_sample  out  1  step strobe to stash
- wr_idx  out  PTR_W  shadow write index
- rd_idx  out  PTR_W  shadow read index (the entry the stash is displaying)
- count  out  PTR_W+1  number of stored samples, saturating at DEPTH
- state  out  2  FSM state: IDLE=0, CAPTURE=1, STEP=2, HOLD=3

Behaviour:
- Reset: clk is the clock; reset is synchronous and active-high. On reset:
  - All outputs go to 0 and state goes to IDLE.
  - Synchronizer flops, debounced levels, debounce counters, pending flag, auto timer and hold counter all clear.
  - Reset asserted mid-operation aborts any strobe or hold in progress at the next edge.
- Synchronizer: each button passes through a 2-flop synchronizer, so the synchronized value reflects the raw input after 2 edges.
- Debounce (per button):
  - The counter clears whenever the synchronized value equals the debounced level.
  - Otherwise it increments. At the edge where the counter equals DEB_CYCLES-1 and the values still differ, the debounced level takes the synchronized value and the counter clears.
- Request generation: a request is the rising edge of the debounced level (level & ~previous level), one cycle wide. Release edges produce nothing.
- Strobes are Moore outputs:
  - sample_in_valid = (state == CAPTURE).
  - next_sample = (state == STEP).
  - Each is exactly one cycle wide, and the two are never high together.
- FSM transitions:
  - IDLE:
    - Capture wins if a sample request is present or the pending flag is set: go to CAPTURE and clear pending.
    - Otherwise, if (next request OR auto tick) and count ≠ 0: go to STEP.
    - A next request with count == 0 is dropped.
  - CAPTURE: go to HOLD. Same edge: rd_idx ← wr_idx; wr_idx ← (wr_idx == DEPTH-1) ? 0 : wr_idx+1; count ← min(count+1, DEPTH).
  - STEP: go to HOLD. Same edge: rd_idx ← (rd_idx == DEPTH-1) ? 0 : rd_idx+1.
  - HOLD: the hold counter runs 0..HOLDOFF-1, then the FSM returns to IDLE.
- Requests outside IDLE:
  - A sample request sets the one-deep pending flag. Further sample requests are absorbed.
  - Next requests are dropped.
- Auto timer:
  - Increments each IDLE cycle while auto_en = 1 and count ≠ 0.
  - The tick fires in the IDLE cycle where timer == STEP_PERIOD-1.
  - Clears outside IDLE, when auto_en = 0, or when a capture is taken.
  - Auto-step period is STEP_PERIOD + 1 + HOLDOFF cycles (11 with defaults).
- Simultaneous requests in IDLE: sample and next/tick together → CAPTURE; the next/tick is discarded.

Test Plan:
1. Reset, then hold btn_sample=1 from just before edge 0 → debounced level rises at edge 6; sample_in_valid=1 only between edges 7 and 8; then wr_idx=1, rd_idx=0, count=1, state HOLD for 2 cycles, then IDLE.
2. btn_sample glitch high for 3 cycles, then low → no strobe, count stays 0. Press btn_next with count=0 → no next_sample.
3. Six captures with DEPTH=5 → wr_idx sequence 1,2,3,4,0,1; count saturates at 5; rd_idx=0 after the sixth capture. Then five btn_next presses → rd_idx 1,2,3,4,0.
4. auto_en=1 with count=2 → next_sample pulses every 11 cycles; rd_idx alternates through the wrap. Drop auto_en → pulses stop and the timer is 0.
5. Sample press debounced during HOLD → pending set; CAPTURE occurs in the first cycle after returning to IDLE. A next press during HOLD is dropped (rd_idx unchanged).
6. Assert reset during CAPTURE → next cycle all outputs 0 and state IDLE; the in-flight count update does not occur.
